// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//   Multi-lane circular instruction queue between fetch and decode/rename.
//   Fetch pushes up to LANES instructions per cycle.
//   Decode pops 0..LANES instructions per cycle.
//   Each entry is tagged with a wrapping sequence number when it is enqueued.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      discard every entry at the next edge (sequence tags continue)
//   enq_valid  per-lane valid mask; valid lanes are compacted in lane order
//   enq_inst   lane i at [i*INST_W +: INST_W]
//   enq_ready  at least LANES free entries (depends on current count only)
//   deq_num    number of entries consumed this cycle (clamped to count)
//   deq_valid  bit i = count > i
//   deq_inst   lane i = entry head+i
//   deq_seq    sequence tag of each dequeue lane
//   count      occupied entries
//   empty      count == 0
//   full       count == DEPTH
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int unsigned INST_W = 10,
  parameter int unsigned LANES  = 3,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SEQ_W  = 6,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned LN_W  = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        enq_valid,
  input  logic [LANES*INST_W-1:0] enq_inst,
  output logic                    enq_ready,
  input  logic [LN_W-1:0]         deq_num,
  output logic [LANES-1:0]        deq_valid,
  output logic [LANES*INST_W-1:0] deq_inst,
  output logic [LANES*SEQ_W-1:0]  deq_seq,
  output logic [CNT_W-1:0]        count,
  output logic                    empty,
  output logic                    full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Storage is never reset or cleared; validity is tracked by head/count.
  logic [INST_W-1:0] r_inst [DEPTH];
  logic [SEQ_W-1:0]  r_seq  [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [SEQ_W-1:0]  r_seq_next;

  logic [LN_W-1:0]   w_n_enq;
  logic [LN_W-1:0]   w_prefix [LANES];
  logic [INST_W-1:0] w_comp_inst [LANES];
  logic              w_enq_fire;
  logic [CNT_W-1:0]  w_deq_req;
  logic [CNT_W-1:0]  w_n_deq;
  logic [CNT_W-1:0]  w_n_enq_eff;

  // Popcount of the valid mask and, per lane, the number of valid lanes below it.
  always_comb begin
    w_n_enq = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_prefix[i] = w_n_enq;
      w_n_enq     = w_n_enq + LN_W'(enq_valid[i]);
    end
  end

  // Compaction: lane i lands in burst slot prefix[i].
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      w_comp_inst[k] = '0;
      for (int i = 0; i < int'(LANES); i++) begin
        if (enq_valid[i] && (w_prefix[i] == LN_W'(k))) begin
          w_comp_inst[k] = enq_inst[i*INST_W +: INST_W];
        end
      end
    end
  end

  // Flush wins over enqueue; a blocked bundle is dropped as a whole.
  assign w_enq_fire  = enq_ready && (|enq_valid) && !flush;
  assign w_n_enq_eff = w_enq_fire ? CNT_W'(w_n_enq) : '0;

  // Dequeue requests above the current count are clamped.
  assign w_deq_req = CNT_W'(deq_num);
  assign w_n_deq   = (w_deq_req > r_count) ? r_count : w_deq_req;

  // Pointer, count and sequence state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_seq_next <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_fire) begin
        r_tail     <= r_tail + PTR_W'(w_n_enq);
        r_seq_next <= r_seq_next + SEQ_W'(w_n_enq);
      end
      r_head  <= r_head + PTR_W'(w_n_deq);
      r_count <= r_count + w_n_enq_eff - w_n_deq;
    end
  end

  // Burst write; slot indices wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      for (int k = 0; k < int'(LANES); k++) begin
        if (LN_W'(k) < w_n_enq) begin
          r_inst[r_tail + PTR_W'(k)] <= w_comp_inst[k];
          r_seq[r_tail + PTR_W'(k)]  <= r_seq_next + SEQ_W'(k);
        end
      end
    end
  end

  // Dequeue lanes read consecutive entries starting at head.
  for (genvar i = 0; i < int'(LANES); i++) begin : g_deq
    logic [PTR_W-1:0] w_rd_ptr;
    assign w_rd_ptr                      = r_head + PTR_W'(i);
    assign deq_inst[i*INST_W +: INST_W]  = r_inst[w_rd_ptr];
    assign deq_seq[i*SEQ_W +: SEQ_W]     = r_seq[w_rd_ptr];
    assign deq_valid[i]                  = (r_count > CNT_W'(i));
  end

  assign enq_ready = (r_count <= CNT_W'(DEPTH - LANES));
  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: directed stimulus pushes hand-computed
// {inst, seq} pairs into a scoreboard; a negedge monitor pops them as the
// DUT dequeues. Status outputs are checked directly against constants.
module tb_inst_fetch_queue;

  localparam int unsigned INST_W = 10;
  localparam int unsigned LANES  = 3;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SEQ_W  = 6;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned LN_W   = $clog2(LANES + 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [SEQ_W-1:0]  seq;
  } sb_t;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic [LANES-1:0]        enq_valid;
  logic [LANES*INST_W-1:0] enq_inst;
  logic                    enq_ready;
  logic [LN_W-1:0]         deq_num;
  logic [LANES-1:0]        deq_valid;
  logic [LANES*INST_W-1:0] deq_inst;
  logic [LANES*SEQ_W-1:0]  deq_seq;
  logic [CNT_W-1:0]        count;
  logic                    empty;
  logic                    full;

  sb_t sb[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  inst_fetch_queue #(
    .INST_W(INST_W), .LANES(LANES), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_ready(enq_ready),
    .deq_num(deq_num), .deq_valid(deq_valid), .deq_inst(deq_inst),
    .deq_seq(deq_seq), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_inst(input int i);
    return 32'(deq_inst[i*INST_W +: INST_W]);
  endfunction

  function automatic logic [31:0] lane_seq(input int i);
    return 32'(deq_seq[i*SEQ_W +: SEQ_W]);
  endfunction

  task automatic push(input logic [INST_W-1:0] inst, input logic [SEQ_W-1:0] seq);
    sb.push_back('{inst: inst, seq: seq});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then return to idle just after the edge.
  task automatic cyc(input logic fl, input logic [LANES-1:0] v,
                     input logic [INST_W-1:0] a, input logic [INST_W-1:0] b,
                     input logic [INST_W-1:0] c, input logic [LN_W-1:0] dn);
    flush     = fl;
    enq_valid = v;
    enq_inst  = {c, b, a};
    deq_num   = dn;
    step();
    flush     = 1'b0;
    enq_valid = '0;
    deq_num   = '0;
  endtask

  // Monitor: every consumed valid lane must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (i < int'(deq_num) && deq_valid[i]) begin
          sb_t e;
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL deq_unexpected: lane %0d inst %0h with empty scoreboard", i, lane_inst(i));
          end else begin
            e = sb.pop_front();
            chk("deq_inst", lane_inst(i), 32'(e.inst));
            chk("deq_seq", lane_seq(i), 32'(e.seq));
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    enq_valid = '0;
    enq_inst  = '0;
    deq_num   = '0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Compaction of mask 101.
    push(10'h011, 6'd0);
    push(10'h033, 6'd1);
    cyc(1'b0, 3'b101, 10'h011, 10'h3FF, 10'h033, 2'd0);
    chk("cmp_count", 32'(count), 32'd2);
    chk("cmp_deq_valid", 32'(deq_valid), 32'b011);
    chk("cmp_lane0", lane_inst(0), 32'h011);
    chk("cmp_lane1", lane_inst(1), 32'h033);
    chk("cmp_seq0", lane_seq(0), 32'd0);
    chk("cmp_seq1", lane_seq(1), 32'd1);
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd2);
    chk("drain_empty", 32'(empty), 32'd1);

    // Back-pressure: 3+3 fills to 6, third bundle ignored.
    push(10'h101, 6'd2); push(10'h102, 6'd3); push(10'h103, 6'd4);
    cyc(1'b0, 3'b111, 10'h101, 10'h102, 10'h103, 2'd0);
    push(10'h104, 6'd5); push(10'h105, 6'd6); push(10'h106, 6'd7);
    cyc(1'b0, 3'b111, 10'h104, 10'h105, 10'h106, 2'd0);
    chk("bp_count", 32'(count), 32'd6);
    chk("bp_enq_ready", 32'(enq_ready), 32'd0);
    chk("bp_full", 32'(full), 32'd0);
    cyc(1'b0, 3'b111, 10'h1F1, 10'h1F2, 10'h1F3, 2'd0);
    chk("bp_ignored_count", 32'(count), 32'd6);

    // Position head at 6 with 3 entries, then push/pop across the wrap.
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd3);
    chk("pre_wrap_count_a", 32'(count), 32'd3);
    push(10'h107, 6'd8);
    cyc(1'b0, 3'b001, 10'h107, 10'h0, 10'h0, 2'd1);
    chk("pre_wrap_count_b", 32'(count), 32'd3);
    chk("pre_wrap_lane0", lane_inst(0), 32'h105);
    push(10'h111, 6'd9); push(10'h112, 6'd10); push(10'h113, 6'd11);
    cyc(1'b0, 3'b111, 10'h111, 10'h112, 10'h113, 2'd2);
    chk("wrap_count", 32'(count), 32'd4);
    chk("wrap_lane0", lane_inst(0), 32'h107);
    chk("wrap_lane1", lane_inst(1), 32'h111);
    chk("wrap_lane2", lane_inst(2), 32'h112);
    chk("wrap_seq0", lane_seq(0), 32'd8);

    // Clamp: deq_num above count.
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd3);
    chk("clamp_count_a", 32'(count), 32'd1);
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd3);
    chk("clamp_count_b", 32'(count), 32'd0);

    // Flush priority over enqueue and dequeue; tags continue.
    push(10'h121, 6'd12); push(10'h122, 6'd13);
    cyc(1'b0, 3'b011, 10'h121, 10'h122, 10'h0, 2'd0);
    chk("pre_flush_count", 32'(count), 32'd2);
    sb.delete();
    cyc(1'b1, 3'b111, 10'h1E1, 10'h1E2, 10'h1E3, 2'd3);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    push(10'h131, 6'd14); push(10'h132, 6'd15); push(10'h133, 6'd16);
    cyc(1'b0, 3'b111, 10'h131, 10'h132, 10'h133, 2'd0);
    chk("post_flush_lane0", lane_inst(0), 32'h131);
    chk("post_flush_seq0", lane_seq(0), 32'd14);
    chk("post_flush_seq1", lane_seq(1), 32'd15);
    chk("post_flush_seq2", lane_seq(2), 32'd16);

    // Stream 15 bursts with matching pops to bring seq_next to 62.
    for (int j = 0; j < 15; j++) begin
      logic [INST_W-1:0] base;
      base = INST_W'(10'h200 + j * 4);
      push(base,       SEQ_W'(17 + 3 * j));
      push(base + 10'd1, SEQ_W'(18 + 3 * j));
      push(base + 10'd2, SEQ_W'(19 + 3 * j));
      cyc(1'b0, 3'b111, base, base + 10'd1, base + 10'd2, 2'd3);
    end
    chk("stream_count", 32'(count), 32'd3);
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd3);
    chk("stream_drained", 32'(count), 32'd0);

    // Sequence tag wrap 62, 63, 0.
    push(10'h3A1, 6'd62); push(10'h3A2, 6'd63); push(10'h3A3, 6'd0);
    cyc(1'b0, 3'b111, 10'h3A1, 10'h3A2, 10'h3A3, 2'd0);
    chk("seqwrap_seq0", lane_seq(0), 32'd62);
    chk("seqwrap_seq1", lane_seq(1), 32'd63);
    chk("seqwrap_seq2", lane_seq(2), 32'd0);

    // Fill to DEPTH: 5 entries still accepts a full bundle.
    push(10'h3B1, 6'd1); push(10'h3B2, 6'd2);
    cyc(1'b0, 3'b011, 10'h3B1, 10'h3B2, 10'h0, 2'd0);
    chk("five_count", 32'(count), 32'd5);
    chk("five_enq_ready", 32'(enq_ready), 32'd1);
    push(10'h3C1, 6'd3); push(10'h3C2, 6'd4); push(10'h3C3, 6'd5);
    cyc(1'b0, 3'b111, 10'h3C1, 10'h3C2, 10'h3C3, 2'd0);
    chk("full_count", 32'(count), 32'd8);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_deq_valid", 32'(deq_valid), 32'b111);
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd3);
    chk("mid_count", 32'(count), 32'd5);

    // Asynchronous reset mid-stream with 5 entries.
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_enq_ready", 32'(enq_ready), 32'd1);
    chk("arst_deq_valid", 32'(deq_valid), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    step();
    push(10'h155, 6'd0);
    cyc(1'b0, 3'b001, 10'h155, 10'h0, 10'h0, 2'd0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_seq0", lane_seq(0), 32'd0);
    cyc(1'b0, 3'b000, 10'h0, 10'h0, 10'h0, 2'd1);
    chk("post_rst_empty", 32'(empty), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised multi-lane instruction queue between fetch and decode/rename. It replaces the fixed 3-wide IF/ID pipeline register. Fetch pushes up to LANES instructions per cycle; the consumer pops any number from 0 to LANES per cycle. This decouples fetch stalls from back-end stalls. Each entry receives a wrapping sequence tag at enqueue for downstream ROB ordering, and `flush` empties the queue in one cycle.

## Interface
- `INST_W`, 10, instruction width in bits
- `LANES`, 3, enqueue/dequeue lanes per cycle (1..8)
- `DEPTH`, 8, entries; power of two, ≥ 2*LANES
- `SEQ_W`, 6, sequence tag width
- Derived: `PTR_W` = $clog2(DEPTH); `CNT_W` = $clog2(DEPTH+1); `LN_W` = $clog2(LANES+1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  discard all entries at next edge
- `enq_valid`  in  LANES  per-lane valid mask; any pattern allowed
- `enq_inst`  in  LANES*INST_W  lane i at bits [i*INST_W +: INST_W]
- `enq_ready`  out  1  free entries ≥ LANES
- `deq_num`  in  LN_W  lanes consumed this cycle
- `deq_valid`  out  LANES  bit i = (count > i)
- `deq_inst`  out  LANES*INST_W  lane i = entry head+i (mod DEPTH)
- `deq_seq`  out  LANES*SEQ_W  sequence tag of each dequeue lane
- `count`  out  CNT_W  occupied entries
- `empty`  out  1  count == 0
- `full`  out  1  count == DEPTH

## Operation
- State: storage[DEPTH] of {inst, seq}, `head`/`tail` (PTR_W bits, wrap mod DEPTH), `count`, `seq_next` (SEQ_W bits).
- Enqueue fires when enq_ready=1 and enq_valid≠0.
  - Valid lanes are compacted in ascending lane order into tail, tail+1, and so on.
  - n_enq = popcount(enq_valid).
  - Entry k of the burst gets seq = seq_next+k (mod 2^SEQ_W).
  - seq_next advances by n_enq.
- When enq_ready=0, the whole enqueue bundle is ignored. There is no partial accept.
- Dequeue: n_deq = min(deq_num, count). Values of deq_num above count are clamped and are not an error. head advances by n_deq.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − n_deq.
  - enq_ready is computed from the current count only, with no dependence on deq_num, so there is no combinational enqueue↔dequeue path.
- Flush has priority over enqueue and dequeue in the same cycle.
  - head, tail and count reset to 0.
  - seq_next is kept, so tags continue across flushes.
  - Storage contents are not cleared.
- deq_inst/deq_seq lanes with deq_valid=0 are don't-care. The bench must not check them.
- Reset: head=tail=count=seq_next=0. Outputs at reset: enq_ready=1, deq_valid=0, count=0, empty=1, full=0.

## Timing
- All state updates on the rising clk edge; rst acts immediately, independent of clk.
- deq_* outputs and count/empty/full/enq_ready are combinational from registered state only.
- Enqueue-to-dequeue latency is 1 cycle: an instruction enqueued at edge t is visible on deq lane 0 in the cycle after t, if the queue was empty.
- Pointer wrap: indices computed mod DEPTH. A burst straddling entry DEPTH−1 → 0 must land contiguously in logical order.
- Full: with count > DEPTH−LANES, enq_ready=0 even if enq_valid has fewer than LANES bits set.
- Reset mid-operation: all state returns to reset values asynchronously; no output glitch persists past rst deassertion.

## Test plan
- **Reset/idle:** assert rst mid-stream with count=5 → count=0, empty=1, enq_ready=1, deq_valid=000 immediately.
- **Compaction:** enq_valid=101, lanes {0x011, —, 0x033}, deq_num=0 → next cycle count=2, deq_valid=011, deq_inst lane0=0x011, lane1=0x033, deq_seq=0,1.
- **Back-pressure:** enqueue 3+3 with deq_num=0 → count=6, enq_ready=0. A further enq_valid=111 is ignored; count stays 6 and seq_next stays 6.
- **Simultaneous push/pop with wrap:** start head=6, count=3. Enqueue 3 and deq_num=2 → count=4, head=0, tail=4 (mod 8). deq lane0 holds the old entry at index 0 (position 8 mod 8) followed by the new entries, in order.
- **Clamp and flush priority:**
  - count=1, deq_num=3 → count=0.
  - Next, flush=1 with enq_valid=111 and seq_next=9 → count=0. A following enqueue tags entries 9, 10, 11.
- **Seq wrap:** with seq_next=62, enqueue 3 → tags 62, 63, 0.
